alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- One ALU execution lane: the receiving end of the issue interface driven by the unified issue queue.
- Three instances sit downstream of the issue queue, one per ALU. Each accepts issued packets, advertises `FU_ready` back to the queue, and computes the ALU result or memory effective address.
- Results wait in a 2-entry in-order result queue and are presented to the ROB/writeback bus with a valid/grant handshake.

Parameters:
- ALU_ID, 0, lane index (0..2); packets accepted only when `aluNum_in` equals it.
- PREG_W, 6, physical register tag width.
- ROB_W, 16, ROB tag width (matches the issue-side ROB number width).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- optype_in  in  4  issued op code; 0 = no issue this cycle
- aluNum_in  in  2  target ALU of the issued packet
- PC_in  in  32  instruction PC (carried through)
- srcReg1_data_in  in  32  operand 1
- srcReg2_data_in  in  32  operand 2 / store data
- imm_in  in  32  sign-extended immediate; for LUI already shifted left 12
- destReg_in  in  PREG_W  destination physical register
- ROBNum_in  in  ROB_W  ROB tag
- flush_in  in  1  synchronous pipeline flush
- FU_ready_out  out  1  lane can accept a packet this cycle
- wb_valid_out  out  1  head of result queue valid
- wb_grant_in  in  1  consumer takes head this cycle
- wb_PC_out  out  32  head PC
- wb_data_out  out  32  ALU result, or effective address for memory ops
- wb_destReg_out  out  PREG_W  head destination
- wb_ROBNum_out  out  ROB_W  head ROB tag
- wb_is_mem_out  out  1  head is load/store
- wb_is_store_out  out  1  head is store
- wb_store_data_out  out  32  `srcReg2` of a store; 0 otherwise
- wb_size_out  out  2  0 = byte (LB/SB), 2 = word (LW/SW), 0 for ALU ops

Behaviour:
- **Accept condition:** `optype_in` in 1..10, `aluNum_in == ALU_ID`, `FU_ready_out == 1` and `flush_in == 0`, sampled at a rising `clk` edge.
  - Codes 11..15, code 0 and an `aluNum` mismatch are silently ignored.
  - The issue queue drives `optype` 0 on non-issue cycles, so no separate valid bit is used.
- **EX stage:** on accept, the packet is registered into the EX stage (edge E0).
- **Result queue write:** at the next edge (E1), the result computed from the EX registers is written into the result queue, provided the queue has space or the head pops on that same edge.
  - `wb_valid_out` is high after E1. Minimum latency is 2 edges from accept to visible writeback.
- **EX stall:** EX holds its contents while the queue is full and `wb_grant_in == 0`.
- **`FU_ready_out`:** equals NOT(`ex_valid` AND queue count == 2).
  - Driven from registered state only; there is no combinational path from `wb_grant_in` or the issue inputs.
- **Results by op code:**
  - ADD(1): s1 + s2
  - ADDI(2): s1 + imm
  - LUI(3): imm
  - ORI(4): s1 | imm
  - XOR(5): s1 ^ s2
  - SRAI(6): s1 >>> imm[4:0] (arithmetic)
  - LB(7), LW(8), SB(9), SW(10): address = s1 + imm
  - All arithmetic is modulo 2^32; carry is discarded.
- **Result queue:** 2 entries, strict FIFO.
  - Head pops at an edge where `wb_valid_out` and `wb_grant_in` are both high.
  - `wb_grant_in` while the queue is empty is ignored.
  - A push and a pop in the same cycle are legal and the count is unchanged.
  - Queue pointers wrap modulo 2.
- **Head outputs:** `wb_*` fields are stable while `wb_valid_out` is high and no grant occurs. They read 0 when the queue is empty.
- **Flush:** `flush_in` at an edge clears the EX stage and the result queue.
  - Any issue presented in the same cycle is discarded.
  - Next cycle: `FU_ready_out` = 1 and `wb_valid_out` = 0.
- **Reset:** `rstn` low asynchronously clears the EX stage and the queue. All `wb_*` outputs are 0 and `FU_ready_out` is 1, during and after reset.
  - Reset mid-operation drops all in-flight packets with no partial writeback.

Decomposition:
- Shared package `uarch_pkg`:
  - op-code constants ADD=1 … SW=10 and NOP=0
  - PREG_W, ROB_W
  - size encodings (byte = 0, word = 2)
  - This package is also used by the issue queue and ROB.
- One sub-module, `fu_result_fifo`: the 2-entry result queue with flush, exposing count and head.

Test Plan:
- Reset: assert `rstn` low with EX and queue occupied → immediately `wb_valid_out` = 0 and all `wb_*` = 0; after release, `FU_ready_out` = 1.
- ALU_ID=1, grant tied 1, issue ADD s1=5, s2=7, dest=9, ROB=3, aluNum=1 → `wb_valid_out` high 2 edges later with data 12, dest 9, ROB 3, `is_mem` = 0; one cycle only.
- Back-to-back issues:
  - SRAI s1=0x80000000, imm=4 → 0xF8000000
  - LUI imm=0x12345000 → 0x12345000
  - ORI s1=0xF0, imm=0x0F → 0xFF
  - XOR 0xFF ^ 0x0F → 0xF0
  - Results appear in issue order.
- Backpressure: grant = 0, issue 3 ADDs on consecutive cycles → `FU_ready_out` drops after the third; then raise grant → all three drain in order and `FU_ready_out` returns to 1.
- Ignore cases: `aluNum` mismatch, `optype` = 0, `optype` = 11, and an issue while `FU_ready_out` = 0 → no state change and no writeback.
- Memory ops and flush:
  - SW s1=0x100, imm=0xFFFFFFFC, s2=0xDEAD → data 0xFC, `is_mem` = 1, `is_store` = 1, `store_data` = 0xDEAD, `size` = 2.
  - LB → `size` = 0, `is_store` = 0.
  - Then flush with queue full and EX valid → next cycle empty, `FU_ready_out` = 1, and the simultaneous issue is dropped.

Source files
------------

// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - shared op codes, widths and ALU result helpers for issue queue, ALU lanes and ROB
package uarch_pkg;

   localparam int PREG_W = 6;
   localparam int ROB_W  = 16;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_ADDI = 4'd2,
      OP_LUI  = 4'd3,
      OP_ORI  = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRAI = 4'd6,
      OP_LB   = 4'd7,
      OP_LW   = 4'd8,
      OP_SB   = 4'd9,
      OP_SW   = 4'd10
   } op_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic op_is_valid(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SW);
   endfunction

   function automatic logic op_is_mem(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == OP_SB) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [3:0] op);
      logic [1:0] sz;
      sz = SIZE_BYTE;
      if ((op == OP_LW) || (op == OP_SW))
         sz = SIZE_WORD;
      return sz;
   endfunction

   // Memory ops reuse the adder to form the effective address s1 + imm.
   function automatic logic [31:0] alu_compute(input logic [3:0] op,
                                               input logic [31:0] s1,
                                               input logic [31:0] s2,
                                               input logic [31:0] imm);
      logic [31:0] r;
      case (op)
         OP_ADD:                     r = s1 + s2;
         OP_ADDI:                    r = s1 + imm;
         OP_LUI:                     r = imm;
         OP_ORI:                     r = s1 | imm;
         OP_XOR:                     r = s1 ^ s2;
         OP_SRAI:                    r = $unsigned($signed(s1) >>> imm[4:0]);
         OP_LB, OP_LW, OP_SB, OP_SW: r = s1 + imm;
         default:                    r = 32'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// rtl/fu_result_fifo.sv - 2-entry in-order result queue with flush, count and zeroed head when empty
module fu_result_fifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic         head_valid,
   output logic [W-1:0] head_data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         pop_ok;
   logic         push_ok;

   assign head_valid = (count != 2'd0);
   assign pop_ok     = pop && head_valid;
   // A full queue still takes a push when the head leaves on the same edge.
   assign push_ok    = push && ((count != 2'd2) || pop_ok);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - one ALU lane: accepts issued packets, computes in EX, queues results for writeback
module alu_issue_unit #(
   parameter int ALU_ID = 0,
   parameter int PREG_W = uarch_pkg::PREG_W,
   parameter int ROB_W  = uarch_pkg::ROB_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [3:0]        optype_in,
   input  logic [1:0]        aluNum_in,
   input  logic [31:0]       PC_in,
   input  logic [31:0]       srcReg1_data_in,
   input  logic [31:0]       srcReg2_data_in,
   input  logic [31:0]       imm_in,
   input  logic [PREG_W-1:0] destReg_in,
   input  logic [ROB_W-1:0]  ROBNum_in,
   input  logic              flush_in,
   output logic              FU_ready_out,
   output logic              wb_valid_out,
   input  logic              wb_grant_in,
   output logic [31:0]       wb_PC_out,
   output logic [31:0]       wb_data_out,
   output logic [PREG_W-1:0] wb_destReg_out,
   output logic [ROB_W-1:0]  wb_ROBNum_out,
   output logic              wb_is_mem_out,
   output logic              wb_is_store_out,
   output logic [31:0]       wb_store_data_out,
   output logic [1:0]        wb_size_out
);

   import uarch_pkg::*;

   // Entry layout: pc, data, dest, rob, is_mem, is_store, store_data, size.
   localparam int ENT_W = 32 + 32 + PREG_W + ROB_W + 1 + 1 + 32 + 2;

   logic              ex_valid;
   logic [3:0]        ex_op;
   logic [31:0]       ex_pc;
   logic [31:0]       ex_s1;
   logic [31:0]       ex_s2;
   logic [31:0]       ex_imm;
   logic [PREG_W-1:0] ex_dest;
   logic [ROB_W-1:0]  ex_rob;

   logic [1:0]        q_count;
   logic              q_full;
   logic              q_head_valid;
   logic              q_pop;
   logic              q_push;
   logic              accept;
   logic [31:0]       ex_result;
   logic              ex_is_store;
   logic [ENT_W-1:0]  ex_entry;
   logic [ENT_W-1:0]  head_entry;

   assign q_full       = (q_count == 2'd2);
   assign FU_ready_out = !(ex_valid && q_full);
   assign q_pop        = q_head_valid && wb_grant_in;
   assign q_push       = ex_valid && (!q_full || q_pop);

   assign accept = op_is_valid(optype_in) && (aluNum_in == ALU_ID[1:0])
                   && FU_ready_out && !flush_in;

   assign ex_result   = alu_compute(ex_op, ex_s1, ex_s2, ex_imm);
   assign ex_is_store = op_is_store(ex_op);
   assign ex_entry    = {ex_pc, ex_result, ex_dest, ex_rob,
                         op_is_mem(ex_op), ex_is_store,
                         ex_is_store ? ex_s2 : 32'd0,
                         op_size(ex_op)};

   // EX holds whenever its packet cannot move into the queue.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_valid <= 1'b0;
         ex_op    <= 4'd0;
         ex_pc    <= 32'd0;
         ex_s1    <= 32'd0;
         ex_s2    <= 32'd0;
         ex_imm   <= 32'd0;
         ex_dest  <= '0;
         ex_rob   <= '0;
      end else if (flush_in) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex_op    <= optype_in;
         ex_pc    <= PC_in;
         ex_s1    <= srcReg1_data_in;
         ex_s2    <= srcReg2_data_in;
         ex_imm   <= imm_in;
         ex_dest  <= destReg_in;
         ex_rob   <= ROBNum_in;
      end else if (q_push) begin
         ex_valid <= 1'b0;
      end
   end

   fu_result_fifo #(
      .W (ENT_W)
   ) u_result_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush_in),
      .push       (q_push),
      .push_data  (ex_entry),
      .pop        (q_pop),
      .count      (q_count),
      .head_valid (q_head_valid),
      .head_data  (head_entry)
   );

   assign wb_valid_out = q_head_valid;
   assign {wb_PC_out, wb_data_out, wb_destReg_out, wb_ROBNum_out,
           wb_is_mem_out, wb_is_store_out, wb_store_data_out, wb_size_out} = head_entry;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - self-checking bench for alu_issue_unit with ALU_ID = 1
module tb_alu_issue_unit;

   localparam int PW = 6;
   localparam int RW = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic [3:0]    optype_in;
   logic [1:0]    aluNum_in;
   logic [31:0]   PC_in;
   logic [31:0]   srcReg1_data_in;
   logic [31:0]   srcReg2_data_in;
   logic [31:0]   imm_in;
   logic [PW-1:0] destReg_in;
   logic [RW-1:0] ROBNum_in;
   logic          flush_in;
   logic          FU_ready_out;
   logic          wb_valid_out;
   logic          wb_grant_in;
   logic [31:0]   wb_PC_out;
   logic [31:0]   wb_data_out;
   logic [PW-1:0] wb_destReg_out;
   logic [RW-1:0] wb_ROBNum_out;
   logic          wb_is_mem_out;
   logic          wb_is_store_out;
   logic [31:0]   wb_store_data_out;
   logic [1:0]    wb_size_out;

   alu_issue_unit #(.ALU_ID(1), .PREG_W(PW), .ROB_W(RW)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .optype_in         (optype_in),
      .aluNum_in         (aluNum_in),
      .PC_in             (PC_in),
      .srcReg1_data_in   (srcReg1_data_in),
      .srcReg2_data_in   (srcReg2_data_in),
      .imm_in            (imm_in),
      .destReg_in        (destReg_in),
      .ROBNum_in         (ROBNum_in),
      .flush_in          (flush_in),
      .FU_ready_out      (FU_ready_out),
      .wb_valid_out      (wb_valid_out),
      .wb_grant_in       (wb_grant_in),
      .wb_PC_out         (wb_PC_out),
      .wb_data_out       (wb_data_out),
      .wb_destReg_out    (wb_destReg_out),
      .wb_ROBNum_out     (wb_ROBNum_out),
      .wb_is_mem_out     (wb_is_mem_out),
      .wb_is_store_out   (wb_is_store_out),
      .wb_store_data_out (wb_store_data_out),
      .wb_size_out       (wb_size_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]   pc;
      logic [31:0]   data;
      logic [PW-1:0] dest;
      logic [RW-1:0] rob;
      logic          is_mem;
      logic          is_store;
      logic [31:0]   sd;
      logic [1:0]    size;
   } ent_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] imm;
      logic [31:0] data;
      logic        is_mem;
      logic        is_store;
      logic [31:0] sd;
      logic [1:0]  size;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t mq[$];
   bit   mex_v;
   ent_t mex;
   ent_t dut_head;
   logic [31:0] pc_ctr = 32'h1000;
   vec_t vecs[10];

   assign dut_head = {wb_PC_out, wb_data_out, wb_destReg_out, wb_ROBNum_out,
                      wb_is_mem_out, wb_is_store_out, wb_store_data_out, wb_size_out};

   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] s1,
                                              input logic [31:0] s2, input logic [31:0] imm);
      logic signed [31:0] ss;
      ss = s1;
      case (op)
         4'd1:                 return s1 + s2;
         4'd2:                 return s1 + imm;
         4'd3:                 return imm;
         4'd4:                 return s1 | imm;
         4'd5:                 return s1 ^ s2;
         4'd6:                 return ss >>> imm[4:0];
         4'd7, 4'd8, 4'd9, 4'd10: return s1 + imm;
         default:              return 32'd0;
      endcase
   endfunction

   function automatic ent_t make_ent(input logic [3:0] op, input logic [31:0] pc,
                                     input logic [31:0] s1, input logic [31:0] s2,
                                     input logic [31:0] imm, input logic [PW-1:0] dest,
                                     input logic [RW-1:0] rob);
      ent_t e;
      e.pc       = pc;
      e.data     = ref_result(op, s1, s2, imm);
      e.dest     = dest;
      e.rob      = rob;
      e.is_mem   = (op >= 4'd7) && (op <= 4'd10);
      e.is_store = (op == 4'd9) || (op == 4'd10);
      e.sd       = e.is_store ? s2 : 32'd0;
      e.size     = ((op == 4'd8) || (op == 4'd10)) ? 2'd2 : 2'd0;
      return e;
   endfunction

   function automatic logic m_ready();
      return !(mex_v && (mq.size() == 2));
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      mex_v = 1'b0;
   endtask

   // Advance the reference model by one edge from the inputs currently applied.
   task automatic model_step();
      bit pop, full, rdy, push;
      if (!rstn) begin
         model_clear();
         return;
      end
      pop  = (mq.size() > 0) && wb_grant_in;
      full = (mq.size() == 2);
      rdy  = m_ready();
      if (flush_in) begin
         model_clear();
         return;
      end
      push = mex_v && (!full || pop);
      if (pop)
         void'(mq.pop_front());
      if (push)
         mq.push_back(mex);
      if (optype_in >= 4'd1 && optype_in <= 4'd10 && aluNum_in == 2'd1 && rdy) begin
         mex   = make_ent(optype_in, PC_in, srcReg1_data_in, srcReg2_data_in, imm_in,
                          destReg_in, ROBNum_in);
         mex_v = 1'b1;
      end else if (push) begin
         mex_v = 1'b0;
      end
   endtask

   task automatic compare_model();
      ent_t exp_head;
      exp_head = '0;
      if (mq.size() > 0)
         exp_head = mq[0];
      check("fu_ready", FU_ready_out, m_ready());
      check("wb_valid", wb_valid_out, mq.size() > 0);
      check("wb_head", dut_head, exp_head);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] alu, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] imm,
                        input logic [PW-1:0] dest, input logic [RW-1:0] rob);
      optype_in       = op;
      aluNum_in       = alu;
      srcReg1_data_in = s1;
      srcReg2_data_in = s2;
      imm_in          = imm;
      destReg_in      = dest;
      ROBNum_in       = rob;
      PC_in           = pc_ctr;
      pc_ctr          = pc_ctr + 32'd4;
   endtask

   task automatic nop();
      optype_in = 4'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, wb_valid_out, 1'b0);
      check({tag, "_head"}, dut_head, '0);
      check({tag, "_ready"}, FU_ready_out, 1'b1);
   endtask

   initial begin
      vecs[0] = '{4'd6,  32'h80000000, 32'h0,    32'h4,        32'hF8000000, 1'b0, 1'b0, 32'h0,    2'd0};
      vecs[1] = '{4'd3,  32'hAAAA5555, 32'h1,    32'h12345000, 32'h12345000, 1'b0, 1'b0, 32'h0,    2'd0};
      vecs[2] = '{4'd4,  32'hF0,       32'h0,    32'h0F,       32'hFF,       1'b0, 1'b0, 32'h0,    2'd0};
      vecs[3] = '{4'd5,  32'hFF,       32'h0F,   32'h0,        32'hF0,       1'b0, 1'b0, 32'h0,    2'd0};
      vecs[4] = '{4'd2,  32'hFFFFFFFF, 32'h0,    32'h1,        32'h0,        1'b0, 1'b0, 32'h0,    2'd0};
      vecs[5] = '{4'd6,  32'h7FFFFFFF, 32'h0,    32'hFFFFFFE3, 32'h0FFFFFFF, 1'b0, 1'b0, 32'h0,    2'd0};
      vecs[6] = '{4'd10, 32'h100,      32'hDEAD, 32'hFFFFFFFC, 32'hFC,       1'b1, 1'b1, 32'hDEAD, 2'd2};
      vecs[7] = '{4'd7,  32'h2000,     32'h77,   32'h5,        32'h2005,     1'b1, 1'b0, 32'h0,    2'd0};
      vecs[8] = '{4'd8,  32'h10,       32'h99,   32'h20,       32'h30,       1'b1, 1'b0, 32'h0,    2'd2};
      vecs[9] = '{4'd9,  32'h0,        32'h55,   32'h7,        32'h7,        1'b1, 1'b1, 32'h55,   2'd0};

      rstn = 1'b1;
      flush_in = 1'b0;
      wb_grant_in = 1'b0;
      issue(4'd0, 2'd0, 32'd0, 32'd0, 32'd0, '0, '0);
      model_clear();
      #1 rstn = 1'b0;
      #1 check_reset_outputs("reset_hold");
      @(posedge clk);
      #1 rstn = 1'b1;
      tick();
      check("ready_after_reset", FU_ready_out, 1'b1);

      // Single ADD with grant tied high: visible 2 edges later, for one cycle.
      wb_grant_in = 1'b1;
      issue(4'd1, 2'd1, 32'd5, 32'd7, 32'd0, 6'd9, 16'd3);
      tick();
      nop();
      tick();
      check("add_valid", wb_valid_out, 1'b1);
      check("add_data", wb_data_out, 32'd12);
      check("add_dest", wb_destReg_out, 6'd9);
      check("add_rob", wb_ROBNum_out, 16'd3);
      check("add_is_mem", wb_is_mem_out, 1'b0);
      tick();
      check("add_one_cycle", wb_valid_out, 1'b0);

      // Back-to-back table vectors; each result is checked two edges after its issue.
      for (int j = 0; j <= 10; j++) begin
         if (j < 10)
            issue(vecs[j].op, 2'd1, vecs[j].s1, vecs[j].s2, vecs[j].imm, PW'(j + 20), RW'(j + 100));
         else
            nop();
         tick();
         if (j >= 1) begin
            check($sformatf("vec%0d_valid", j - 1), wb_valid_out, 1'b1);
            check($sformatf("vec%0d_data", j - 1), wb_data_out, vecs[j-1].data);
            check($sformatf("vec%0d_tags", j - 1), {wb_destReg_out, wb_ROBNum_out},
                  {PW'(j + 19), RW'(j + 99)});
            check($sformatf("vec%0d_mem", j - 1),
                  {wb_is_mem_out, wb_is_store_out, wb_store_data_out, wb_size_out},
                  {vecs[j-1].is_mem, vecs[j-1].is_store, vecs[j-1].sd, vecs[j-1].size});
         end
      end
      tick();
      check("table_drained", wb_valid_out, 1'b0);

      // Backpressure: three ADDs with no grant fill EX and both queue slots.
      wb_grant_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         issue(4'd1, 2'd1, 32'(k), 32'(k), 32'd0, 6'd1, 16'(k));
         tick();
      end
      check("bp_ready_low", FU_ready_out, 1'b0);
      check("bp_head0", wb_data_out, 32'd2);
      issue(4'd1, 2'd1, 32'd100, 32'd100, 32'd0, 6'd1, 16'd9);
      tick();
      check("bp_drop_ready", FU_ready_out, 1'b0);
      check("bp_drop_head", wb_data_out, 32'd2);
      nop();
      wb_grant_in = 1'b1;
      tick();
      check("bp_head1", wb_data_out, 32'd4);
      check("bp_ready_back", FU_ready_out, 1'b1);
      tick();
      check("bp_head2", wb_data_out, 32'd6);
      tick();
      check("bp_empty", wb_valid_out, 1'b0);
      tick();
      check("bp_no_dropped", wb_valid_out, 1'b0);

      // Ignored issues: wrong lane, NOP code, codes above SW.
      issue(4'd1, 2'd2, 32'd1, 32'd1, 32'd0, 6'd1, 16'd1);
      tick();
      check("ign_alunum", wb_valid_out, 1'b0);
      issue(4'd0, 2'd1, 32'd1, 32'd1, 32'd1, 6'd1, 16'd1);
      tick();
      check("ign_op0", wb_valid_out, 1'b0);
      issue(4'd11, 2'd1, 32'd1, 32'd1, 32'd1, 6'd1, 16'd1);
      tick();
      check("ign_op11", wb_valid_out, 1'b0);
      issue(4'd15, 2'd1, 32'd1, 32'd1, 32'd1, 6'd1, 16'd1);
      tick();
      check("ign_op15", wb_valid_out, 1'b0);
      nop();
      tick();
      check("ign_settle", wb_valid_out, 1'b0);
      check("ign_ready", FU_ready_out, 1'b1);

      // Flush with queue full and EX valid; the simultaneous issue is dropped.
      wb_grant_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         issue(4'd2, 2'd1, 32'h40, 32'd0, 32'(k), 6'd2, 16'(k));
         tick();
      end
      check("fl_pre_ready", FU_ready_out, 1'b0);
      flush_in = 1'b1;
      issue(4'd1, 2'd1, 32'd7, 32'd7, 32'd0, 6'd3, 16'd3);
      tick();
      check("fl_valid", wb_valid_out, 1'b0);
      check("fl_ready", FU_ready_out, 1'b1);
      flush_in = 1'b0;
      nop();
      tick();
      check("fl_drop1", wb_valid_out, 1'b0);
      tick();
      check("fl_drop2", wb_valid_out, 1'b0);

      // Asynchronous reset mid-cycle with EX and queue occupied.
      for (int k = 0; k < 3; k++) begin
         issue(4'd5, 2'd1, 32'hFFFF, 32'(k), 32'd0, 6'd4, 16'(k));
         tick();
      end
      nop();
      #3 rstn = 1'b0;
      model_clear();
      #1 check_reset_outputs("async_reset");
      tick();
      rstn = 1'b1;
      tick();
      check("post_reset_ready", FU_ready_out, 1'b1);
      check("post_reset_valid", wb_valid_out, 1'b0);

      // Random traffic against the reference model, light then heavy grant rates.
      for (int c = 0; c < 3000; c++) begin
         int gprob;
         gprob = (c < 1500) ? 30 : 85;
         issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom, $urandom,
               $urandom, PW'($urandom), RW'($urandom));
         wb_grant_in = ($urandom_range(0, 99) < gprob);
         flush_in    = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush_in = 1'b0;
      nop();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
